// File: rtl/sar_adc_ctrl_if.sv
// Purpose : bundles the request, comparator, DAC and result signals of the
//           SAR ADC controller into one port.
// Latency : none; wires only.
// Backpressure: result_valid/result_ready handshake; result held until accepted.
// Ports (master = controller side):
//   start        in   conversion request, level-sampled
//   comp_in      in   asynchronous comparator output, 1 = Vin >= Vdac
//   result_ready in   consumer accepts result
//   dac_code     out  registered trial/final code to the DAC
//   sample_hold  out  1 = track, 0 = hold
//   busy         out  conversion in progress
//   result       out  last completed conversion
//   result_valid out  result available
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             comp_in;
  logic             result_ready;
  logic [WIDTH-1:0] dac_code;
  logic             sample_hold;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    input  start,
    input  comp_in,
    input  result_ready,
    output dac_code,
    output sample_hold,
    output busy,
    output result,
    output result_valid
  );

  modport slave (
    output start,
    output comp_in,
    output result_ready,
    input  dac_code,
    input  sample_hold,
    input  busy,
    input  result,
    input  result_valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Purpose : successive-approximation ADC controller; drives trial codes into the
//           DAC, samples an external comparator, returns the converted code.
// Latency : SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles from start to result_valid.
// Backpressure: result/result_valid held in DONE until result_ready; start ignored meanwhile.
// Ports:
//   CLK    core clock (PLL output)
//   reset  asynchronous active-low reset
//   bus    sar_adc_ctrl_if master modport (start, comp_in, result_ready in;
//          dac_code, sample_hold, busy, result, result_valid out)
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          reset,
  sar_adc_ctrl_if.master bus
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB     = IW'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  if (SAMPLE_CYCLES < 1) begin : g_bad_sample
    $error("sar_adc_ctrl: SAMPLE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 2 to cover the comparator synchronizer");
  end

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic             busy_q;
  logic             sample_hold_q;

  logic             comp_s1;
  logic             comp_s;

  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] next_trial;

  // Two-flop synchronizer; nothing downstream ever looks at raw comp_in.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      comp_s1 <= 1'b0;
      comp_s  <= 1'b0;
    end else begin
      comp_s1 <= bus.comp_in;
      comp_s  <= comp_s1;
    end
  end

  // The DAC register doubles as the working code: the bit under test is
  // replaced by the comparator decision, then the next lower bit is tried.
  always_comb begin
    decided          = dac_q;
    decided[bit_idx] = comp_s;
    next_trial       = decided;
    if (bit_idx != '0) begin
      next_trial[bit_idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      dac_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      sample_hold_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state         <= ST_SAMPLE;
            cnt           <= '0;
            busy_q        <= 1'b1;
            sample_hold_q <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            state         <= ST_SETTLE;
            cnt           <= '0;
            sample_hold_q <= 1'b0;
            bit_idx       <= IDX_MSB;
            dac_q         <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_DECIDE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DECIDE: begin
          if (bit_idx != '0) begin
            dac_q   <= next_trial;
            bit_idx <= bit_idx - 1'b1;
            state   <= ST_SETTLE;
            cnt     <= '0;
          end else begin
            dac_q          <= decided;
            result_q       <= decided;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state          <= ST_DONE;
          end
        end

        ST_DONE: begin
          // start is only honoured on the handshake edge, which allows
          // back-to-back conversions without an idle cycle.
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            if (bus.start) begin
              state         <= ST_SAMPLE;
              cnt           <= '0;
              busy_q        <= 1'b1;
              sample_hold_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: begin
          state          <= ST_IDLE;
          cnt            <= '0;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          sample_hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dac_code     = dac_q;
  assign bus.sample_hold  = sample_hold_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Purpose : directed self-checking bench for sar_adc_ctrl with a comparator model.
// Latency : expects 34 cycles start-to-valid with default parameters.
// Backpressure: exercises result_ready held low, start during DONE, back-to-back.
module tb_sar_adc_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  int         tests = 0;
  int         fails = 0;
  logic [9:0] vin = 10'h3FF;
  logic       async_mode = 1'b0;
  logic       comp_async = 1'b0;
  logic       xbad = 1'b0;
  int         lat;
  logic       seen;
  logic       stable;
  logic [9:0] hold_res;
  int         diff;

  sar_adc_ctrl_if #(.WIDTH(10)) bus ();

  sar_adc_ctrl #(
    .WIDTH(10),
    .SAMPLE_CYCLES(4),
    .SETTLE_CYCLES(2)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Free-running toggle unrelated to CLK: models a metastable comparator
  // when Vin sits exactly on the trial threshold.
  always #13 comp_async = ~comp_async;

  // Comparator model: ideal (Vin >= Vdac) unless async_mode and at threshold.
  assign bus.comp_in = (vin > bus.dac_code) ? 1'b1 :
                       (vin < bus.dac_code) ? 1'b0 :
                       (async_mode ? comp_async : 1'b1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (reset && $isunknown({bus.dac_code, bus.result, bus.sample_hold, bus.busy, bus.result_valid}))
      xbad = 1'b1;
  endtask

  task automatic convert(input logic [9:0] v, output int l);
    vin = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    l = 0;
    while (!bus.result_valid && l < 100) begin
      tick();
      l++;
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.result_ready = 1'b1;

    // Reset state (comparator reads 1 here, synchronizer must still be 0)
    #2;
    repeat (3) @(negedge CLK);
    check("rst_dac", 32'(bus.dac_code), 32'h0);
    check("rst_result", 32'(bus.result), 32'h0);
    check("rst_valid", 32'(bus.result_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_sh", 32'(bus.sample_hold), 32'h0);
    check("rst_sync", 32'({dut.comp_s1, dut.comp_s}), 32'h0);
    reset = 1'b1;
    tick();

    // Ideal conversion of 0x2A5 with trial sequence checks
    vin = 10'h2A5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'h1);
    check("start_sh", 32'(bus.sample_hold), 32'h1);
    repeat (4) tick();
    check("trial0", 32'(bus.dac_code), 32'h200);
    check("trial0_sh", 32'(bus.sample_hold), 32'h0);
    repeat (3) tick();
    check("trial1", 32'(bus.dac_code), 32'h300);
    repeat (3) tick();
    check("trial2", 32'(bus.dac_code), 32'h280);
    lat = 10;
    while (!bus.result_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("lat_2a5", 32'(lat), 32'd34);
    check("res_2a5", 32'(bus.result), 32'h2A5);
    check("busy_done", 32'(bus.busy), 32'h0);
    tick();
    check("hs_valid", 32'(bus.result_valid), 32'h0);
    check("hs_result_kept", 32'(bus.result), 32'h2A5);
    check("idle_dac_kept", 32'(bus.dac_code), 32'h2A5);
    check("idle_sh", 32'(bus.sample_hold), 32'h0);

    // Boundaries
    convert(10'h3FF, lat);
    check("lat_3ff", 32'(lat), 32'd34);
    check("res_3ff", 32'(bus.result), 32'h3FF);
    tick();
    convert(10'h000, lat);
    check("res_000", 32'(bus.result), 32'h000);
    tick();
    convert(10'h200, lat);
    check("res_200", 32'(bus.result), 32'h200);
    tick();

    // Backpressure: 20 cycles of ready=0, with an ignored start pulse
    bus.result_ready = 1'b0;
    convert(10'h1C3, lat);
    check("res_1c3", 32'(bus.result), 32'h1C3);
    hold_res = bus.result;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.start = (k == 5);
      tick();
      if (bus.result_valid !== 1'b1 || bus.result !== hold_res) stable = 1'b0;
    end
    bus.start = 1'b0;
    check("bp_stable", 32'(stable), 32'h1);
    check("bp_start_ignored", 32'({bus.busy, bus.sample_hold}), 32'h0);
    bus.result_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.result_valid), 32'h0);
    tick();
    check("bp_idle", 32'({bus.busy, bus.sample_hold}), 32'h0);

    // Back-to-back: start and ready together on the DONE cycle
    bus.result_ready = 1'b0;
    convert(10'h0F0, lat);
    check("res_0f0", 32'(bus.result), 32'h0F0);
    vin = 10'h155;
    bus.start = 1'b1;
    bus.result_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b_valid_drop", 32'(bus.result_valid), 32'h0);
    check("b2b_sh", 32'(bus.sample_hold), 32'h1);
    lat = 0;
    while (!bus.result_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_lat", 32'(lat), 32'd34);
    check("b2b_res", 32'(bus.result), 32'h155);
    tick();

    // Reset mid-conversion
    vin = 10'h2A5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    check("mid_busy", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    check("arst_dac", 32'(bus.dac_code), 32'h0);
    check("arst_result", 32'(bus.result), 32'h0);
    check("arst_flags", 32'({bus.result_valid, bus.busy, bus.sample_hold}), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      tick();
      if (bus.result_valid || bus.busy) seen = 1'b1;
    end
    check("no_valid_after_rst", 32'(seen), 32'h0);
    convert(10'h3A1, lat);
    check("post_rst_lat", 32'(lat), 32'd34);
    check("post_rst_res", 32'(bus.result), 32'h3A1);
    tick();

    // Metastable comparator at the trial threshold
    async_mode = 1'b1;
    xbad = 1'b0;
    convert(10'h200, lat);
    diff = int'(bus.result) - 32'h200;
    check("meta_200_lsb", 32'(diff >= -1 && diff <= 1), 32'h1);
    tick();
    convert(10'h0AB, lat);
    diff = int'(bus.result) - 32'h0AB;
    check("meta_0ab_lsb", 32'(diff >= -1 && diff <= 1), 32'h1);
    check("meta_lat", 32'(lat), 32'd34);
    tick();
    check("no_x", 32'(xbad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation ADC controller: the read-back direction of the CPU-to-DAC path.
- Drives trial codes into the existing 10-bit DAC (avsddac D input) and samples an external analog comparator (Vin vs DAC OUT).
- Returns a WIDTH-bit conversion result to the RV_CPU side over a valid/ready handshake.
- Runs on the PLL-generated core clock.

Parameters:
- WIDTH, 10: result and DAC code width; must equal the DAC width.
- SAMPLE_CYCLES, 4: cycles sample_hold is asserted per conversion; ≥1.
- SETTLE_CYCLES, 2: wait cycles after each trial code before the decision; ≥2, which covers the comparator synchronizer.

Ports:
- CLK  input  1  core clock (PLL output).
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  conversion request; level-sampled, see Behaviour.
- comp_in  input  1  asynchronous comparator output; 1 = Vin ≥ Vdac.
- result_ready  input  1  consumer accepts result.
- dac_code  output  WIDTH  code to DAC.
- sample_hold  output  1  track/hold control to the analog front end; 1 = track.
- busy  output  1  conversion in progress (SAMPLE/SETTLE/DECIDE).
- result  output  WIDTH  conversion result.
- result_valid  output  1  result available.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - dac_code, result, result_valid, busy and sample_hold all 0.
  - Synchronizer flops 0.
  - Assertion mid-conversion aborts immediately; no partial result is ever flagged valid.
- comp_in passes through a 2-flop synchronizer (comp_s). All decisions use comp_s only.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE. Registers:
  - bit index i, counting WIDTH-1 down to 0.
  - cycle counter cnt, sized for max(SAMPLE_CYCLES, SETTLE_CYCLES).
  - working code.
- IDLE:
  - If start=1 at the edge: go to SAMPLE, cnt=0, busy=1, sample_hold=1.
  - dac_code holds its last value (the previous result, or 0 after reset).
- SAMPLE:
  - sample_hold=1 for exactly SAMPLE_CYCLES cycles.
  - On the edge ending the last one: sample_hold=0, i=WIDTH-1, dac_code = 1<<(WIDTH-1), go to SETTLE, cnt=0.
- SETTLE: hold dac_code for SETTLE_CYCLES cycles, then go to DECIDE.
- DECIDE (1 cycle):
  - Bit i of the code = comp_s. Bit i is kept when comp_s=1 and cleared when comp_s=0.
  - If i>0: set bit i-1 to 1 in the same edge, decrement i, go to SETTLE.
  - If i=0: result = final code, dac_code = final code, result_valid=1, busy=0, go to DONE.
- Latency:
  - From the start-accepting edge to the edge raising result_valid: SAMPLE_CYCLES + WIDTH×(SETTLE_CYCLES+1) cycles.
  - With defaults: 4 + 10×3 = 34 cycles.
- DONE:
  - result and result_valid are held stable while result_ready=0 (backpressure; no timeout).
  - On an edge with result_ready=1: result_valid=0.
  - If start=1 on that same edge: go directly to SAMPLE (back-to-back, no idle cycle). Otherwise go to IDLE.
  - start while result_ready=0 is ignored.
- start during busy is ignored; there is no queueing.
- result retains its value after the handshake until the next conversion completes.
- dac_code changes only on the SAMPLE→SETTLE and DECIDE edges. No glitching combinational path to the DAC; dac_code is a registered output.
- Arithmetic:
  - Unsigned binary codes.
  - An all-ones comparator yields 2^WIDTH-1; an all-zeros comparator yields 0.

Test Plan:
- Ideal comparator model (comp_in = Vin_code ≥ dac_code), Vin_code=0x2A5, single start pulse, result_ready=1:
  - Trial sequence starts 0x200, 0x300, 0x280, …
  - result=0x2A5 with result_valid high exactly 34 cycles after the start edge.
  - busy low in the same cycle.
- Boundaries:
  - Vin_code=0x3FF → result 0x3FF.
  - Vin_code=0x000 → result 0x000.
  - Vin_code=0x200 → result 0x200.
- Backpressure: result_ready=0 for 20 cycles after valid.
  - result and result_valid are stable throughout.
  - A start pulse in that window is ignored.
  - Raising ready → valid drops next edge, state returns to IDLE.
- Back-to-back: start=1 and result_ready=1 in the DONE cycle, second Vin_code=0x155.
  - sample_hold rises the next cycle.
  - Second result 0x155 appears 34 cycles after the handshake edge.
- Reset mid-conversion: drive reset=0 at cycle 15 of a conversion.
  - All outputs are 0 asynchronously.
  - After release, no result_valid without a new start.
  - A new conversion completes correctly.
- Metastability tolerance: comp_in toggles asynchronously (random offset relative to CLK, e.g. a 41.665 ns period against a different clock).
  - No X on any output.
  - Result differs from the ideal code by at most 1 LSB only when Vin is at a trial threshold.
